// File: rtl/f_pc_unit.sv
// Fetch-stage PC generator with a circular return-address stack
// that predicts jr $ra targets and tallies prediction hits/misses.
module f_pc_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] EXC_ENTRY  = 32'h0000_4180,
    parameter bit          ERET_PLUS4 = 1'b1,
    parameter int          RAS_DEPTH  = 4,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             req,
    input  logic             eret,
    input  logic [31:0]      epc,
    input  logic [2:0]       npc_op,
    input  logic [15:0]      offset,
    input  logic [25:0]      instr_index,
    input  logic [31:0]      jr_reg,
    input  logic [31:0]      d_pc,
    input  logic             zero,
    input  logic             ret_hint,
    output logic [31:0]      npc,
    output logic [31:0]      f_pc,
    output logic [31:0]      ras_top,
    output logic             ras_valid,
    output logic [CNT_W-1:0] ras_hit_cnt,
    output logic [CNT_W-1:0] ras_miss_cnt
);

    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [PW:0] FULL = (PW+1)'(RAS_DEPTH);

    localparam logic [2:0] OP_BR   = 3'd1;
    localparam logic [2:0] OP_JAL  = 3'd2;
    localparam logic [2:0] OP_JR   = 3'd3;
    localparam logic [2:0] OP_JALR = 3'd4;

    logic [31:0]      pc_q, pc_d;
    logic [PW-1:0]    sp_q, sp_d;
    logic [PW:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0] hit_q, hit_d;
    logic [CNT_W-1:0] miss_q, miss_d;
    logic [31:0]      ras_q [RAS_DEPTH];

    logic [PW-1:0] sp_m1;
    logic          advance;
    logic          push;
    logic          pop;
    logic [31:0]   br_tgt;

    assign sp_m1     = sp_q - 1'b1;
    assign advance   = !reset && !req && !stall;
    assign push      = advance && (npc_op == OP_JAL || npc_op == OP_JALR);
    assign pop       = advance && (npc_op == OP_JR) && ret_hint;
    assign br_tgt    = d_pc + 32'd4 + {{14{offset[15]}}, offset, 2'b00};
    assign ras_valid = (cnt_q != '0);
    assign ras_top   = ras_valid ? ras_q[sp_m1] : 32'd0;

    always_comb begin
        npc = pc_q + 32'd4;
        if (req)
            npc = EXC_ENTRY;
        else if (eret)
            npc = ERET_PLUS4 ? epc + 32'd4 : epc;
        else if (npc_op == OP_JR || npc_op == OP_JALR)
            npc = jr_reg;
        else if (npc_op == OP_BR && zero)
            npc = br_tgt;
        else if (npc_op == OP_JAL)
            npc = {d_pc[31:28], instr_index, 2'b00};
    end

    always_comb begin
        pc_d = pc_q;
        if (req)
            pc_d = EXC_ENTRY;
        else if (!stall)
            pc_d = npc;
    end

    // An empty-stack pop is a miss but leaves the pointers alone.
    always_comb begin
        sp_d   = sp_q;
        cnt_d  = cnt_q;
        hit_d  = hit_q;
        miss_d = miss_q;
        if (push) begin
            sp_d = sp_q + 1'b1;
            if (cnt_q != FULL)
                cnt_d = cnt_q + 1'b1;
        end else if (pop) begin
            if (ras_valid) begin
                sp_d  = sp_m1;
                cnt_d = cnt_q - 1'b1;
                if (ras_top == jr_reg) begin
                    if (!(&hit_q))
                        hit_d = hit_q + 1'b1;
                end else if (!(&miss_q)) begin
                    miss_d = miss_q + 1'b1;
                end
            end else if (!(&miss_q)) begin
                miss_d = miss_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q   <= RESET_PC;
            sp_q   <= '0;
            cnt_q  <= '0;
            hit_q  <= '0;
            miss_q <= '0;
            for (int i = 0; i < RAS_DEPTH; i++)
                ras_q[i] <= 32'd0;
        end else begin
            pc_q   <= pc_d;
            sp_q   <= sp_d;
            cnt_q  <= cnt_d;
            hit_q  <= hit_d;
            miss_q <= miss_d;
            if (push)
                ras_q[sp_q] <= d_pc + 32'd8;
        end
    end

    assign f_pc         = pc_q;
    assign ras_hit_cnt  = hit_q;
    assign ras_miss_cnt = miss_q;

endmodule

// File: tb/tb_f_pc_unit.sv
// Bench for f_pc_unit: queue-based reference model checked every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_f_pc_unit;

    localparam int DEPTH = 4;
    localparam int CW    = 16;

    logic        clk = 1'b0;
    logic        reset, stall, req, eret, zero, ret_hint;
    logic [31:0] epc, jr_reg, d_pc;
    logic [2:0]  npc_op;
    logic [15:0] offset;
    logic [25:0] instr_index;

    logic [31:0]   npc, f_pc, ras_top;
    logic          ras_valid;
    logic [CW-1:0] hit, miss;

    logic [31:0]   npc1, f_pc1, top1;
    logic          valid1;
    logic [CW-1:0] hit1, miss1;

    int checks = 0;
    int errors = 0;

    f_pc_unit #(.RAS_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .stall(stall), .req(req), .eret(eret),
        .epc(epc), .npc_op(npc_op), .offset(offset),
        .instr_index(instr_index), .jr_reg(jr_reg), .d_pc(d_pc),
        .zero(zero), .ret_hint(ret_hint), .npc(npc), .f_pc(f_pc),
        .ras_top(ras_top), .ras_valid(ras_valid),
        .ras_hit_cnt(hit), .ras_miss_cnt(miss)
    );

    f_pc_unit #(.ERET_PLUS4(1'b0), .RAS_DEPTH(DEPTH), .CNT_W(CW)) u1 (
        .clk(clk), .reset(reset), .stall(stall), .req(req), .eret(eret),
        .epc(epc), .npc_op(npc_op), .offset(offset),
        .instr_index(instr_index), .jr_reg(jr_reg), .d_pc(d_pc),
        .zero(zero), .ret_hint(ret_hint), .npc(npc1), .f_pc(f_pc1),
        .ras_top(top1), .ras_valid(valid1),
        .ras_hit_cnt(hit1), .ras_miss_cnt(miss1)
    );

    always #5 clk = ~clk;

    // reference model state
    logic [31:0] m_pc;
    logic [31:0] rq[$];
    int          m_hit, m_miss;
    localparam int CMAX = (1 << CW) - 1;

    function automatic logic [31:0] m_npc();
        logic [31:0] s;
        s = {{16{offset[15]}}, offset};
        if (req) return 32'h4180;
        if (eret) return epc + 4;
        if (npc_op == 3 || npc_op == 4) return jr_reg;
        if (npc_op == 1 && zero) return d_pc + 4 + s * 4;
        if (npc_op == 2) return {d_pc[31:28], instr_index, 2'b00};
        return m_pc + 4;
    endfunction

    function automatic logic [31:0] m_top();
        return (rq.size() > 0) ? rq[rq.size()-1] : 32'd0;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_pc = 32'h3000;
            rq.delete();
            m_hit = 0;
            m_miss = 0;
        end else if (req) begin
            m_pc = 32'h4180;
        end else if (!stall) begin
            if (npc_op == 2 || npc_op == 4) begin
                if (rq.size() == DEPTH) void'(rq.pop_front());
                rq.push_back(d_pc + 8);
            end else if (npc_op == 3 && ret_hint) begin
                if (rq.size() == 0) begin
                    if (m_miss < CMAX) m_miss++;
                end else begin
                    if (rq[rq.size()-1] == jr_reg) begin
                        if (m_hit < CMAX) m_hit++;
                    end else if (m_miss < CMAX) m_miss++;
                    void'(rq.pop_back());
                end
            end
            m_pc = m_npc();
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            chk("npc", npc, m_npc());
            chk("f_pc", f_pc, m_pc);
            chk("ras_top", ras_top, m_top());
            chk("ras_valid", {31'd0, ras_valid}, {31'd0, rq.size() != 0});
            chk("hit_cnt", {16'd0, hit}, m_hit);
            chk("miss_cnt", {16'd0, miss}, m_miss);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        stall = 0; req = 0; eret = 0; npc_op = 0; zero = 0; ret_hint = 0;
    endtask

    task automatic call(input logic [31:0] pc);
        idle();
        npc_op = 2; d_pc = pc; instr_index = 26'h0000C00;
        step();
    endtask

    task automatic ret(input logic [31:0] tgt);
        idle();
        npc_op = 3; ret_hint = 1; jr_reg = tgt;
        step();
    endtask

    logic [31:0] held;

    initial begin
        reset = 1; idle();
        epc = 0; offset = 0; instr_index = 0; jr_reg = 0; d_pc = 0;
        step(); step();
        reset = 0;
        #1 chk("rst_pc", f_pc, 32'h3000);
        chk("rst_valid", {31'd0, ras_valid}, 32'd0);
        chk("rst_hit", {16'd0, hit}, 32'd0);
        step(); chk("seq1", f_pc, 32'h3004);
        step(); chk("seq2", f_pc, 32'h3008);
        step(); chk("seq3", f_pc, 32'h300C);

        npc_op = 1; d_pc = 32'h3010; offset = 16'hFFFF; zero = 1;
        #1 chk("br_taken", npc, 32'h3010);
        step();
        zero = 0;
        #1 chk("br_not", npc, 32'h3014);
        step();

        call(32'h3020);
        chk("jal_top", ras_top, 32'h3028);
        ret(32'h3028);
        chk("ret_hit", {16'd0, hit}, 32'd1);
        chk("ret_empty", {31'd0, ras_valid}, 32'd0);
        call(32'h3100);
        ret(32'h4000);
        chk("ret_miss", {16'd0, miss}, 32'd1);

        for (int i = 0; i < 5; i++) call(32'h5000 + i * 32'h100);
        chk("ovf_top", ras_top, 32'h5408);
        for (int i = 4; i > 0; i--) ret(32'h5008 + i * 32'h100);
        ret(32'h5008);
        chk("ovf_hit", {16'd0, hit}, 32'd5);
        chk("ovf_miss", {16'd0, miss}, 32'd2);

        idle();
        held = f_pc;
        stall = 1; npc_op = 2; d_pc = 32'h6000;
        step();
        chk("stall_pc", f_pc, held);
        chk("stall_ras", {31'd0, ras_valid}, 32'd0);
        req = 1;
        step();
        chk("req_pc", f_pc, 32'h4180);
        chk("req_ras", {31'd0, ras_valid}, 32'd0);

        idle();
        call(32'h7000);
        idle();
        eret = 1; epc = 32'h3100;
        #1 chk("eret_p4", npc, 32'h3104);
        chk("eret_p0", npc1, 32'h3100);
        req = 1;
        #1 chk("req_eret", npc, 32'h4180);
        chk("req_eret1", npc1, 32'h4180);
        step();
        chk("keep_ras", ras_top, 32'h7008);

        idle();
        npc_op = 3; jr_reg = 32'h7008;
        step();
        chk("jr_nohint", ras_top, 32'h7008);
        npc_op = 4; ret_hint = 1; d_pc = 32'h8000; jr_reg = 32'h3000;
        step();
        chk("jalr_push", ras_top, 32'h8008);

        idle();
        reset = 1; npc_op = 2; d_pc = 32'h9000;
        step();
        reset = 0; idle();
        #1 chk("rst2_valid", {31'd0, ras_valid}, 32'd0);
        chk("rst2_hit", {16'd0, hit}, 32'd0);
        chk("rst2_miss", {16'd0, miss}, 32'd0);
        step(); step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/f_pc_unit.md
Name: f_pc_unit

Overview:
- Fetch-stage PC generator: owns the F-stage PC register and computes the next PC from D-stage control flow, exception request and eret.
- Adds a parametrised circular return-address stack (RAS) that predicts `jr $ra` targets and keeps saturating hit/miss counters for performance analysis.
- Sits between the F-stage IM address and the D-stage decoder/comparator; D-stage resolution still decides the actual jr target.

Parameters:
- RESET_PC, 32'h0000_3000, value loaded into f_pc on reset.
- EXC_ENTRY, 32'h0000_4180, exception/interrupt handler entry.
- ERET_PLUS4, 1, 1: eret returns to epc+4; 0: eret returns to epc.
- RAS_DEPTH, 4, number of RAS entries; power of two, ≥2.
- CNT_W, 16, width of the hit/miss counters.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hazard stall; hold f_pc and freeze RAS.
- req  in  1  exception/interrupt request from CP0.
- eret  in  1  eret in D stage.
- epc  in  32  CP0 EPC.
- npc_op  in  3  0 seq, 1 branch, 2 jal, 3 jr, 4 jalr; 5–7 behave as seq.
- offset  in  16  branch immediate.
- instr_index  in  26  jal target field.
- jr_reg  in  32  forwarded rs value for jr/jalr.
- d_pc  in  32  PC of the D-stage instruction.
- zero  in  1  branch condition true.
- ret_hint  in  1  D-stage jr uses rs==$31.
- npc  out  32  combinational next PC.
- f_pc  out  32  registered fetch PC.
- ras_top  out  32  current RAS prediction; 0 when empty.
- ras_valid  out  1  RAS non-empty.
- ras_hit_cnt  out  CNT_W  correct return predictions.
- ras_miss_cnt  out  CNT_W  wrong or empty predictions.

Behaviour:
- npc priority, combinational:
  - req → EXC_ENTRY.
  - eret → epc + (ERET_PLUS4 ? 4 : 0).
  - op jr or jalr → jr_reg.
  - op branch and zero → d_pc + 4 + sext(offset) << 2.
  - op jal → {d_pc[31:28], instr_index, 2'b00}.
  - otherwise → f_pc + 4.
  - All arithmetic is 32-bit and wraps modulo 2^32.
- f_pc register, on posedge clk:
  - reset → RESET_PC.
  - else if req → EXC_ENTRY. This overrides stall.
  - else if stall → hold.
  - else → npc.
- advance = !reset && !req && !stall. The RAS and counters change only when advance is true.
- Push: on advance with op jal or jalr, write d_pc + 8 at sp, sp ← sp + 1 mod RAS_DEPTH, count ← min(count + 1, RAS_DEPTH).
- Overflow: a push when full overwrites the oldest entry (circular); count stays at RAS_DEPTH.
- Pop: on advance with op jr and ret_hint:
  - If count > 0: compare ras_top with jr_reg. Equal → hit_cnt++, otherwise miss_cnt++. Then sp ← sp − 1, count − 1.
  - If count == 0: miss_cnt++ and pointers are unchanged.
- jr without ret_hint: no RAS effect.
- jalr with ret_hint: push only, no pop.
- Counters saturate at all-ones; no wrap.
- ras_top = entry[sp − 1] when count > 0, else 0. ras_valid = (count != 0). Both are combinational from registered state.
- reset: f_pc = RESET_PC, sp = 0, count = 0, entries = 0, both counters = 0. reset wins over req, stall and all pushes/pops in the same cycle.
- req and eret asserted together: req wins. No RAS action that cycle.
- The RAS is not flushed on exception or eret. Contents survive the handler.

Test Plan:
- Reset, then 3 unstalled seq cycles → f_pc goes 0x3000, 0x3004, 0x3008, 0x300C; ras_valid = 0; counters = 0.
- d_pc = 0x3010, op branch, offset = 16'hFFFF, zero = 1 → npc = 0x3010. Same with zero = 0 → npc = f_pc + 4.
- jal at d_pc = 0x3020 → ras_top = 0x3028. Then jr + ret_hint with jr_reg = 0x3028 → hit_cnt = 1, ras_valid = 0. Repeat with jr_reg = 0x4000 after a new push → miss_cnt = 1.
- RAS_DEPTH = 4, push 5 returns (A..E), then pop 5 times with matching targets → hits for E, D, C, B; fifth pop on empty → miss_cnt + 1.
- stall = 1 with jal pending → f_pc and RAS unchanged. Add req = 1 in the same cycle → f_pc = 0x4180 next cycle, no push.
- eret with epc = 0x3100: ERET_PLUS4 = 1 → npc = 0x3104; ERET_PLUS4 = 0 → npc = 0x3100. With req + eret together → npc = 0x4180.
